// File: rtl/sub64_stream_stage_pkg.sv
// ----------------------------------------------------------------------------
// sub64_stream_stage_pkg: shared operand width, FIFO occupancy type and helper.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sub64_stream_stage_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  // Occupancy after one edge; push and pop together leave it unchanged.
  function automatic occ_e occ_next(input occ_e cur, input logic push, input logic pop);
    occ_e nxt;
    nxt = cur;
    case ({push, pop})
      2'b10:   nxt = (cur == EMPTY) ? ONE : FULL;
      2'b01:   nxt = (cur == FULL) ? ONE : EMPTY;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sub64_fifo2.sv
// ----------------------------------------------------------------------------
// sub64_fifo2: two-entry pointer FIFO; caller never pushes when FULL or pops when EMPTY.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sub64_fifo2
  import sub64_stream_stage_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output occ_e             count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  occ_e             count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = occ_next(count_q, push, pop);
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= EMPTY;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

`default_nettype wire

// File: rtl/sub64_stream_stage.sv
// ----------------------------------------------------------------------------
// sub64_stream_stage: buffered 64-bit subtract stage with tag, flags and op counter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sub64_stream_stage
  import sub64_stream_stage_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int TAG_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_diff,
  output logic              out_borrow,
  output logic              out_zero,
  output logic [TAG_W-1:0]  out_tag,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  op_count
);

  localparam int ENTRY_W = TAG_W + 2 * DATA_W;

  logic               in_hs, out_hs, load;
  logic [ENTRY_W-1:0] head;
  occ_e               occ;
  logic [TAG_W-1:0]   head_tag;
  logic [DATA_W-1:0]  head_a, head_b;
  logic [DATA_W:0]    sub_full;

  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_diff_q, out_diff_d;
  logic               out_borrow_q, out_borrow_d;
  logic               out_zero_q, out_zero_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;

  sub64_fifo2 #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_hs),
    .push_data ({in_tag, in_a, in_b}),
    .pop       (load),
    .head_data (head),
    .count     (occ)
  );

  assign {head_tag, head_a, head_b} = head;

  always_comb begin
    in_hs    = in_valid && in_ready_q;
    out_hs   = out_valid_q && out_ready;
    load     = (occ != EMPTY) && (!out_valid_q || out_ready);
    // Bit DATA_W of the zero-extended difference is the borrow.
    sub_full = {1'b0, head_a} - {1'b0, head_b};

    // Registered from next occupancy so in_ready never sees out_ready combinationally.
    in_ready_d = (occ_next(occ, in_hs, load) != FULL);

    out_valid_d  = out_valid_q;
    out_diff_d   = out_diff_q;
    out_borrow_d = out_borrow_q;
    out_zero_d   = out_zero_q;
    out_tag_d    = out_tag_q;
    if (load) begin
      out_valid_d  = 1'b1;
      out_diff_d   = sub_full[DATA_W-1:0];
      out_borrow_d = sub_full[DATA_W];
      out_zero_d   = (sub_full[DATA_W-1:0] == '0);
      out_tag_d    = head_tag;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end

    op_count_d = op_count_q;
    if (cnt_clr) begin
      op_count_d = '0;
    end else if (out_hs) begin
      op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_diff_q   <= '0;
      out_borrow_q <= 1'b0;
      out_zero_q   <= 1'b0;
      out_tag_q    <= '0;
      op_count_q   <= '0;
    end else begin
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_diff_q   <= out_diff_d;
      out_borrow_q <= out_borrow_d;
      out_zero_q   <= out_zero_d;
      out_tag_q    <= out_tag_d;
      op_count_q   <= op_count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_diff   = out_diff_q;
  assign out_borrow = out_borrow_q;
  assign out_zero   = out_zero_q;
  assign out_tag    = out_tag_q;
  assign op_count   = op_count_q;

endmodule

`default_nettype wire

// File: tb/tb_sub64_stream_stage.sv
// ----------------------------------------------------------------------------
// tb_sub64_stream_stage: directed stimulus with a queue-based result model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sub64_stream_stage;

  localparam int TAG_W = 8;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic [63:0]      in_a = '0;
  logic [63:0]      in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_ready = 1'b0;
  logic             cnt_clr = 1'b0;

  wire              in_ready, out_valid, out_borrow, out_zero;
  wire [63:0]       out_diff;
  wire [TAG_W-1:0]  out_tag;
  wire [CNT_W-1:0]  op_count;

  wire              in_ready_s, out_valid_s, out_borrow_s, out_zero_s;
  wire [63:0]       out_diff_s;
  wire [TAG_W-1:0]  out_tag_s;
  wire [2:0]        op_count_s;

  sub64_stream_stage #(.CNT_W(CNT_W), .TAG_W(TAG_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_diff(out_diff), .out_borrow(out_borrow),
    .out_zero(out_zero), .out_tag(out_tag), .cnt_clr(cnt_clr), .op_count(op_count)
  );

  // Narrow-counter copy on the same stimulus exercises counter wrap quickly.
  sub64_stream_stage #(.CNT_W(3), .TAG_W(TAG_W)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_diff(out_diff_s), .out_borrow(out_borrow_s),
    .out_zero(out_zero_s), .out_tag(out_tag_s), .cnt_clr(cnt_clr), .op_count(op_count_s)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]      diff;
    logic             borrow;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } res_t;

  res_t        q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] mcnt = '0;
  bit          last_pushed = 1'b0;
  bit          armed = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic [TAG_W-1:0] t);
    res_t r;
    r.diff   = a - b;
    r.borrow = (a < b);
    r.zero   = (a == b);
    r.tag    = t;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // Mid-cycle compare against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    int held;
    if (!rst_n) begin
      q.delete();
      mcnt        = '0;
      last_pushed = 1'b0;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_diff", out_diff, 64'd0);
      chk("rst_flags", {62'd0, out_borrow, out_zero}, 64'd0);
      chk("rst_out_tag", {56'd0, out_tag}, 64'd0);
      chk("rst_op_count", {32'd0, op_count}, 64'd0);
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", {63'd0, out_valid}, 64'd0);
        end else begin
          chk("m_diff", out_diff, q[0].diff);
          chk("m_borrow", {63'd0, out_borrow}, {63'd0, q[0].borrow});
          chk("m_zero", {63'd0, out_zero}, {63'd0, q[0].zero});
          chk("m_tag", {56'd0, out_tag}, {56'd0, q[0].tag});
        end
      end else if (q.size() != 0) begin
        chk("m_latency", {63'd0, (q.size() == 1) && last_pushed}, 64'd1);
      end
      held = q.size() - (out_valid ? 1 : 0);
      if (armed) chk("m_in_ready", {63'd0, in_ready}, {63'd0, held < 2});
      chk("m_op_count", {32'd0, op_count}, {32'd0, mcnt});
      chk("m_op_count_s", {61'd0, op_count_s}, {61'd0, mcnt[2:0]});

      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      last_pushed = in_valid && in_ready;
      if (last_pushed) q.push_back(model(in_a, in_b, in_tag));
      if (cnt_clr)                     mcnt = '0;
      else if (out_valid && out_ready) mcnt = mcnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b,
                      input logic [TAG_W-1:0] t, output bit ok);
    bit hs;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
    ok       = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      hs = in_ready;
      tick();
      if (hs) ok = 1'b1;
    end
  endtask

  task automatic clear_count();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  initial begin
    bit ok;
    int seen, gapped, gap, stalls;
    logic [63:0] ra, rb;

    #2 rst_n = 1'b0;
    #1;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    chk("post_rst_in_ready_low", {63'd0, in_ready}, 64'd0);
    tick();
    chk("post_rst_in_ready_high", {63'd0, in_ready}, 64'd1);

    // Single op and latency.
    out_ready = 1'b1;
    send(64'h10, 64'h3, 8'h5A, ok);
    in_valid = 1'b0;
    chk("single_accept", {63'd0, ok}, 64'd1);
    chk("single_not_yet", {63'd0, out_valid}, 64'd0);
    tick();
    chk("single_valid", {63'd0, out_valid}, 64'd1);
    chk("single_diff", out_diff, 64'hD);
    chk("single_flags", {62'd0, out_borrow, out_zero}, 64'd0);
    chk("single_tag", {56'd0, out_tag}, 64'h5A);
    tick();
    chk("single_count", {32'd0, op_count}, 64'd1);
    chk("single_drop", {63'd0, out_valid}, 64'd0);

    // Borrow wrap then equal operands.
    send(64'h0, 64'h1, 8'h01, ok);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 8'h02, ok);
    in_valid = 1'b0;
    chk("wrap_diff", out_diff, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wrap_borrow_zero", {62'd0, out_borrow, out_zero}, 64'd2);
    tick();
    chk("eq_diff", out_diff, 64'd0);
    chk("eq_borrow_zero", {62'd0, out_borrow, out_zero}, 64'd1);
    chk("eq_tag", {56'd0, out_tag}, 64'h02);
    tick();
    chk("wrap_count", {32'd0, op_count}, 64'd3);

    // Backpressure: three accepted, fourth refused, outputs held.
    clear_count();
    out_ready = 1'b0;
    send(64'h100, 64'h1, 8'h11, ok);
    chk("bp_acc1", {63'd0, ok}, 64'd1);
    send(64'h200, 64'h2, 8'h22, ok);
    chk("bp_acc2", {63'd0, ok}, 64'd1);
    send(64'h300, 64'h3, 8'h33, ok);
    chk("bp_acc3", {63'd0, ok}, 64'd1);
    in_a   = 64'h400;
    in_b   = 64'h4;
    in_tag = 8'h44;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_hold_diff", out_diff, 64'hFF);
      chk("bp_hold_tag", {56'd0, out_tag}, 64'h11);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_r2", out_diff, 64'h1FE);
    chk("bp_r2_tag", {56'd0, out_tag}, 64'h22);
    tick();
    chk("bp_r3", out_diff, 64'h2FD);
    tick();
    chk("bp_done", {63'd0, out_valid}, 64'd0);
    chk("bp_count", {32'd0, op_count}, 64'd3);

    // Streaming 100 back-to-back ops.
    clear_count();
    seen = 0; gapped = 0; gap = 0; stalls = 0;
    for (int i = 0; i < 100; i++) begin
      ra = {$urandom, $urandom};
      rb = (i % 7 == 0) ? ra : {$urandom, $urandom};
      ok = 1'b0;
      for (int k = 0; k < 10 && !ok; k++) begin
        if (!in_ready) stalls++;
        ok = in_ready;
        in_valid = 1'b1; in_a = ra; in_b = rb; in_tag = i[7:0];
        tick();
        if (out_valid) begin
          if (gapped != 0) gap = 1;
          seen++;
        end else if (seen > 0) gapped = 1;
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (out_valid) begin
        if (gapped != 0) gap = 1;
        seen++;
      end else if (seen > 0) gapped = 1;
    end
    chk("stream_results", seen, 64'd100);
    chk("stream_gap", gap, 64'd0);
    chk("stream_stalls", stalls, 64'd0);
    chk("stream_count", {32'd0, op_count}, 64'd100);

    // Counter wrap on the narrow copy, then clear coincident with a handshake.
    clear_count();
    for (int i = 0; i < 7; i++) send(64'(i + 5), 64'd2, 8'(i), ok);
    in_valid = 1'b0;
    tick(); tick();
    chk("cnt7_s", {61'd0, op_count_s}, 64'd7);
    send(64'd9, 64'd9, 8'hA0, ok);
    in_valid = 1'b0;
    tick(); tick();
    chk("cnt_wrap_s", {61'd0, op_count_s}, 64'd0);
    chk("cnt8", {32'd0, op_count}, 64'd8);
    send(64'd50, 64'd8, 8'hC1, ok);
    in_valid = 1'b0;
    tick();
    chk("clr_hs_valid", {63'd0, out_valid}, 64'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_hs_count", {32'd0, op_count}, 64'd0);
    chk("clr_hs_count_s", {61'd0, op_count_s}, 64'd0);

    // Reset mid-flight with FIFO full and a result pending.
    out_ready = 1'b0;
    send(64'h77, 64'h7, 8'h71, ok);
    send(64'h88, 64'h8, 8'h72, ok);
    send(64'h99, 64'h9, 8'h73, ok);
    in_valid = 1'b0;
    chk("mf_valid", {63'd0, out_valid}, 64'd1);
    chk("mf_full", {63'd0, in_ready}, 64'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("mf_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mf_rst_diff", out_diff, 64'd0);
    chk("mf_rst_tag", {56'd0, out_tag}, 64'd0);
    chk("mf_rst_count", {32'd0, op_count}, 64'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    chk("mf_rel_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    chk("mf_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("mf_no_stale", {63'd0, out_valid}, 64'd0);
      tick();
    end
    chk("mf_count", {32'd0, op_count}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
